// File: rtl/writeback_arbiter_pkg.sv
// Shared types for the writeback arbiter: data word, register address and result source.
package writeback_arbiter_pkg;

  typedef logic [31:0] Word;
  typedef logic [4:0]  RegAddress;

  localparam int unsigned NumRegs = 32;

  typedef enum logic {
    WbAlu = 1'b0,
    WbLsu = 1'b1
  } WbSource;

endpackage

// File: rtl/writeback_arbiter_pending_scoreboard.sv
// Per-register pending-write counters; drives issue_ready and the busy vector for hazard checks.
module pending_scoreboard
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned COUNT_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_valid,
  input  RegAddress          issue_rd,
  output logic               issue_ready,
  input  RegAddress          commit_addr,
  output logic [NumRegs-1:0] busy
);

  localparam logic [COUNT_W-1:0] CountMax = '1;
  localparam logic [COUNT_W-1:0] CountOne = COUNT_W'(1);

  logic [COUNT_W-1:0] count_q [NumRegs];
  logic [COUNT_W-1:0] count_d [NumRegs];
  logic               inc_en;
  logic               dec_en;

  assign dec_en = (commit_addr != '0);

  // A commit to a saturated register frees a slot at the same edge the issue would take it.
  assign issue_ready = (issue_rd == '0) || (count_q[issue_rd] != CountMax) ||
                       (commit_addr == issue_rd);
  assign inc_en = issue_valid && issue_ready && (issue_rd != '0);

  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      count_d[i] = count_q[i];
    end
    if (inc_en) begin
      count_d[issue_rd] = count_d[issue_rd] + CountOne;
    end
    if (dec_en && count_q[commit_addr] != '0) begin
      count_d[commit_addr] = count_d[commit_addr] - CountOne;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        count_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        count_q[i] <= count_d[i];
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 1; i < NumRegs; i++) begin
      busy[i] = (count_q[i] != '0);
    end
  end

  underflow_chk: assert property (@(posedge clk) disable iff (reset)
      !(dec_en && count_q[commit_addr] == '0))
    else $error("pending_scoreboard: commit to r%0d with no pending write", commit_addr);

endmodule

// File: rtl/writeback_arbiter.sv
// Arbitrates ALU and LSU results onto the register file write port and tracks pending writes.
// WRITEBACK_BYPASS_EN adds a read bypass from the wb register; WRITEBACK_TRACE prints commits.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned COUNT_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_valid,
  input  RegAddress          issue_rd,
  output logic               issue_ready,
  input  logic               alu_valid,
  output logic               alu_ready,
  input  RegAddress          alu_rd,
  input  Word                alu_value,
  input  logic               lsu_valid,
  output logic               lsu_ready,
  input  RegAddress          lsu_rd,
  input  Word                lsu_value,
`ifdef WRITEBACK_BYPASS_EN
  input  RegAddress          rs1_addr,
  input  RegAddress          rs2_addr,
  input  Word                rf_out1,
  input  Word                rf_out2,
  output Word                rs1_value,
  output Word                rs2_value,
`endif
  output RegAddress          wb_addr,
  output Word                wb_data,
  output logic [NumRegs-1:0] busy
);

  // Also identifies the source of the entry currently in the wb register.
  WbSource last_grant_q;
  logic    alu_fire;
  logic    lsu_fire;

  // Under contention the source that did not win last time gets the port.
  assign alu_ready = !(lsu_valid && last_grant_q == WbAlu);
  assign lsu_ready = !(alu_valid && last_grant_q == WbLsu);
  assign alu_fire  = alu_valid && alu_ready;
  assign lsu_fire  = lsu_valid && lsu_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_addr      <= '0;
      wb_data      <= '0;
      last_grant_q <= WbAlu;
    end else if (alu_fire) begin
      wb_addr      <= alu_rd;
      wb_data      <= alu_value;
      last_grant_q <= WbAlu;
    end else if (lsu_fire) begin
      wb_addr      <= lsu_rd;
      wb_data      <= lsu_value;
      last_grant_q <= WbLsu;
    end else begin
      wb_addr      <= '0;
    end
  end

  pending_scoreboard #(
    .COUNT_W (COUNT_W)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .commit_addr (wb_addr),
    .busy        (busy)
  );

`ifdef WRITEBACK_BYPASS_EN
  // The register file returns the old value on the same edge it writes, so forward wb_data.
  assign rs1_value = (wb_addr != '0 && wb_addr == rs1_addr) ? wb_data : rf_out1;
  assign rs2_value = (wb_addr != '0 && wb_addr == rs2_addr) ? wb_data : rf_out2;
`endif

`ifdef WRITEBACK_TRACE
  always_ff @(posedge clk) begin
    if (!reset && wb_addr != '0) begin
      $display("TRACE wb src=%s rd=%0d value=%08h", last_grant_q.name(), wb_addr, wb_data);
    end
  end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with a cycle-level reference model and per-cycle compare.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  localparam int CntMax = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid, issue_ready;
  RegAddress   issue_rd;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
  RegAddress   alu_rd, lsu_rd;
  Word         alu_value, lsu_value;
  RegAddress   wb_addr;
  Word         wb_data;
  logic [31:0] busy;
`ifdef WRITEBACK_BYPASS_EN
  RegAddress   rs1_addr, rs2_addr;
  Word         rf_out1, rf_out2, rs1_value, rs2_value;
`endif

  writeback_arbiter #(
    .COUNT_W (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_value   (alu_value),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_value   (lsu_value),
`ifdef WRITEBACK_BYPASS_EN
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rf_out1     (rf_out1),
    .rf_out2     (rf_out2),
    .rs1_value   (rs1_value),
    .rs2_value   (rs2_value),
`endif
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: outstanding-write count per register, who was served last, wb entry.
  int          m_cnt [32];
  bit          m_last_lsu;
  logic [4:0]  m_wb_addr;
  logic [31:0] m_wb_data;
  bit          go_alu, go_lsu, go_iss;

  function automatic bit m_alu_wins();
    if (!alu_valid) return 1'b0;
    if (!lsu_valid) return 1'b1;
    return m_last_lsu;
  endfunction

  function automatic bit m_lsu_wins();
    if (!lsu_valid) return 1'b0;
    if (!alu_valid) return 1'b1;
    return !m_last_lsu;
  endfunction

  function automatic bit m_issue_ok();
    return (issue_rd == 0) || (m_cnt[issue_rd] < CntMax) || (m_wb_addr == issue_rd);
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] v;
    v = '0;
    for (int i = 1; i < 32; i++) v[i] = (m_cnt[i] > 0);
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_last_lsu = 1'b0;
      m_wb_addr  = '0;
      m_wb_data  = '0;
    end else begin
      go_alu = m_alu_wins();
      go_lsu = m_lsu_wins();
      go_iss = issue_valid && m_issue_ok() && (issue_rd != 0);
      if (m_wb_addr != 0 && m_cnt[m_wb_addr] > 0) m_cnt[m_wb_addr]--;
      if (go_iss) m_cnt[issue_rd]++;
      if (go_alu) begin
        m_wb_addr  = alu_rd;
        m_wb_data  = alu_value;
        m_last_lsu = 1'b0;
      end else if (go_lsu) begin
        m_wb_addr  = lsu_rd;
        m_wb_data  = lsu_value;
        m_last_lsu = 1'b1;
      end else begin
        m_wb_addr = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (alu_valid) check("alu_ready", alu_ready, m_alu_wins());
      if (lsu_valid) check("lsu_ready", lsu_ready, m_lsu_wins());
      if (issue_valid) check("issue_ready", issue_ready, m_issue_ok());
      check("wb_addr", wb_addr, m_wb_addr);
      if (m_wb_addr != 0) check("wb_data", wb_data, m_wb_data);
      check("busy", busy, m_busy());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          ai, li, cyc;
  bit          ga, gl;
  logic [4:0]  alu_q [2];
  logic [4:0]  lsu_q [2];

  initial begin
    issue_valid = 0; issue_rd = '0;
    alu_valid = 0; alu_rd = '0; alu_value = '0;
    lsu_valid = 0; lsu_rd = '0; lsu_value = '0;
`ifdef WRITEBACK_BYPASS_EN
    rs1_addr = '0; rs2_addr = '0; rf_out1 = '0; rf_out2 = '0;
`endif
    reset = 1;
    repeat (2) tick();
    reset = 0;
    @(negedge clk);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_busy", busy, 0);
    tick();

    // Issue r5, ALU result 42 into r5.
    issue_valid = 1; issue_rd = 5;
    @(negedge clk);
    check("t1_issue_ready", issue_ready, 1);
    tick();
    issue_valid = 0; alu_valid = 1; alu_rd = 5; alu_value = 42;
    @(negedge clk);
    check("t1_alu_ready", alu_ready, 1);
    check("t1_busy5_set", busy[5], 1);
    tick();
    alu_valid = 0;
    @(negedge clk);
    check("t1_wb_addr", wb_addr, 5);
    check("t1_wb_data", wb_data, 42);
    check("t1_busy5_held", busy[5], 1);
    tick();
    @(negedge clk);
    check("t1_busy5_clear", busy[5], 0);
    check("t1_wb_idle", wb_addr, 0);
    tick();

    // Contention while last grant is ALU: LSU first, then ALU.
    issue_valid = 1; issue_rd = 1; tick();
    issue_rd = 2; tick();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 1; alu_value = 7;
    lsu_valid = 1; lsu_rd = 2; lsu_value = 9;
    @(negedge clk);
    check("t2_lsu_first", lsu_ready, 1);
    check("t2_alu_wait", alu_ready, 0);
    tick();
    lsu_valid = 0;
    @(negedge clk);
    check("t2_wb1_addr", wb_addr, 2);
    check("t2_wb1_data", wb_data, 9);
    check("t2_alu_next", alu_ready, 1);
    tick();
    alu_valid = 0;
    @(negedge clk);
    check("t2_wb2_addr", wb_addr, 1);
    check("t2_wb2_data", wb_data, 7);
    tick();

    // Saturate r3, then a same-edge commit lets the fourth issue through.
    issue_valid = 1; issue_rd = 3;
    repeat (3) tick();
    @(negedge clk);
    check("t3_full", issue_ready, 0);
    tick();
    issue_valid = 0; alu_valid = 1; alu_rd = 3; alu_value = 33;
    tick();
    alu_valid = 0; issue_valid = 1; issue_rd = 3;
    @(negedge clk);
    check("t3_wb_addr", wb_addr, 3);
    check("t3_ready_on_commit", issue_ready, 1);
    tick();
    @(negedge clk);
    check("t3_still_full", issue_ready, 0);
    check("t3_busy3", busy[3], 1);
    tick();
    issue_valid = 0; alu_valid = 1; alu_rd = 3; alu_value = 34;
    repeat (3) tick();
    alu_valid = 0;
    tick();
    @(negedge clk);
    check("t3_drained", busy[3], 0);
    tick();

    // rd=0 result completes without touching the scoreboard.
    issue_valid = 1; issue_rd = 8; tick();
    issue_valid = 0; alu_valid = 1; alu_rd = 0; alu_value = 123;
    @(negedge clk);
    check("t4_alu_ready", alu_ready, 1);
    tick();
    alu_valid = 0;
    @(negedge clk);
    check("t4_wb_addr", wb_addr, 0);
    check("t4_busy", busy, 32'h0000_0100);
    tick();

    // Reset with r4 in flight drops the write and clears every counter.
    issue_valid = 1; issue_rd = 4; tick();
    issue_valid = 0; alu_valid = 1; alu_rd = 4; alu_value = 32'h44; tick();
    alu_valid = 0;
    @(negedge clk);
    check("t5_inflight", wb_addr, 4);
    #1 reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    check("t5_wb_addr", wb_addr, 0);
    check("t5_wb_data", wb_data, 0);
    check("t5_busy", busy, 0);
    tick();

`ifdef WRITEBACK_BYPASS_EN
    issue_valid = 1; issue_rd = 6; tick();
    issue_valid = 0; alu_valid = 1; alu_rd = 6; alu_value = 55; tick();
    alu_valid = 0;
    rs1_addr = 6; rf_out1 = 0; rs2_addr = 7; rf_out2 = 8;
    @(negedge clk);
    check("byp_rs1", rs1_value, 55);
    check("byp_rs2", rs2_value, 8);
    tick();
`endif

    // Back-to-back contended traffic: four results in four cycles.
    for (int r = 10; r < 14; r++) begin
      issue_valid = 1; issue_rd = 5'(r); tick();
    end
    issue_valid = 0;
    alu_q[0] = 10; alu_q[1] = 11; lsu_q[0] = 12; lsu_q[1] = 13;
    ai = 0; li = 0; cyc = 0;
    while (cyc < 8 && (ai < 2 || li < 2)) begin
      alu_valid = (ai < 2); alu_rd = (ai < 2) ? alu_q[ai] : 5'd0; alu_value = 32'h100 + ai;
      lsu_valid = (li < 2); lsu_rd = (li < 2) ? lsu_q[li] : 5'd0; lsu_value = 32'h200 + li;
      @(negedge clk);
      ga = alu_valid && alu_ready;
      gl = lsu_valid && lsu_ready;
      tick();
      if (ga) ai++;
      if (gl) li++;
      cyc++;
    end
    alu_valid = 0; lsu_valid = 0;
    check("t6_cycles", cyc, 4);
    tick();
    @(negedge clk);
    check("t6_drained", busy, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
